arctic_scan_out: RTL and testbench



---
 rtl/arctic_pkg.sv | 27 ++
 rtl/arctic_cell_mux.sv | 24 ++
 rtl/arctic_scan_out.sv | 187 ++++++++++++++++++
 tb/tb_arctic_scan_out.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arctic_pkg.sv
// Shared types and encodings for the Arctic Circle node array and its readout stages.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package arctic_pkg;

    // Width of one node output (direction nibble).
    localparam int CELL_W = 4;

    // Single-direction encodings carried by a node output.
    localparam logic [CELL_W-1:0] DIR_EMPTY = 4'b0000;
    localparam logic [CELL_W-1:0] DIR_D     = 4'b0010;
    localparam logic [CELL_W-1:0] DIR_C     = 4'b0001;
    localparam logic [CELL_W-1:0] DIR_A     = 4'b0100;
    localparam logic [CELL_W-1:0] DIR_B     = 4'b1000;

    // Domino pair encodings (two directions sharing one cell).
    localparam logic [CELL_W-1:0] PAIR_H    = 4'b1010;
    localparam logic [CELL_W-1:0] PAIR_V    = 4'b0101;

    // Scan-out frame sequencer states; CHK is only reachable with the checksum beat enabled.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/arctic_cell_mux.sv
// Selects one cell out of a flattened CELLS x (N+1) array by index.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; an out-of-range index yields all zeros.
module arctic_cell_mux #(
    parameter int N     = 3,
    parameter int CELLS = 16,
    parameter int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1
) (
    input  logic [CELLS*(N+1)-1:0] cells_i,
    input  logic [IDX_W-1:0]       sel_i,
    output logic [N:0]             cell_o
);

    // One-hot compare per cell keeps the select a flat AND-OR tree.
    always_comb begin
        cell_o = '0;
        for (int k = 0; k < CELLS; k++) begin
            if (sel_i == IDX_W'(k)) begin
                cell_o = cells_i[k*(N+1) +: (N+1)];
            end
        end
    end

endmodule

// File: rtl/arctic_scan_out.sv
// Snapshots all node outputs on step and streams them one cell per beat with first/last framing.
// Latency: first beat valid 1 cycle after an accepted step; one beat per cycle while out_ready is high.
// Backpressure: beats hold stable while out_ready is low; steps arriving mid-frame are dropped and
// counted in a saturating overrun counter. ARCTIC_SCAN_CHECKSUM_EN appends an XOR checksum beat.
module arctic_scan_out
    import arctic_pkg::*;
#(
    parameter int N     = CELL_W - 1,
    parameter int CELLS = 16,
    parameter int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1,
    parameter int OVR_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   step,
    input  logic [CELLS*(N+1)-1:0] cells_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N:0]             out_data,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   busy,
    output logic [OVR_W-1:0]       overrun
);

`ifdef ARCTIC_SCAN_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    // Index of the final cell of a frame.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - 1);
    // With a single cell and no checksum beat, cell 0 is also the closing beat.
    localparam bit FIRST_IS_LAST = (CELLS == 1) && !CHK_EN;

    scan_state_t            state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CELLS*(N+1)-1:0] snap_q, snap_d;
    logic                   valid_q, valid_d;
    logic [N:0]             data_q, data_d;
    logic                   first_q, first_d;
    logic                   last_q, last_d;
    logic [OVR_W-1:0]       ovr_q, ovr_d;

    logic                   xfer;
    logic                   final_xfer;
    logic                   start;
    logic                   drop;
    logic [IDX_W-1:0]       idx_inc;
    logic [N:0]             next_cell;

    assign xfer       = valid_q && out_ready;
    // The beat flagged last is the one that closes the frame, whichever state sends it.
    assign final_xfer = xfer && last_q;
    // A step is taken when idle, or when it coincides with the closing transfer (no bubble).
    assign start      = step && ((state_q == IDLE) || final_xfer);
    assign drop       = step && (state_q != IDLE) && !final_xfer;
    assign idx_inc    = idx_q + 1'b1;

    // Next cell is read from the snapshot, never from the live array.
    arctic_cell_mux #(
        .N     (N),
        .CELLS (CELLS),
        .IDX_W (IDX_W)
    ) u_cell_mux (
        .cells_i (snap_q),
        .sel_i   (idx_inc),
        .cell_o  (next_cell)
    );

`ifdef ARCTIC_SCAN_CHECKSUM_EN
    logic [N:0] chk_sum;

    // XOR of every snapshot cell, sent as the trailing beat.
    always_comb begin
        chk_sum = '0;
        for (int k = 0; k < CELLS; k++) begin
            chk_sum = chk_sum ^ snap_q[k*(N+1) +: (N+1)];
        end
    end
`endif

    // Frame sequencing: advance on transfers, start or restart on accepted steps, count drops.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        data_d  = data_q;
        first_d = first_q;
        last_d  = last_q;
        ovr_d   = ovr_q;

        case (state_q)
            IDLE: begin
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_inc;
                        data_d  = next_cell;
                        first_d = 1'b0;
                        last_d  = !CHK_EN && (idx_inc == LAST_IDX);
                    end else begin
`ifdef ARCTIC_SCAN_CHECKSUM_EN
                        state_d = CHK;
                        data_d  = chk_sum;
                        first_d = 1'b0;
                        last_d  = 1'b1;
`else
                        state_d = IDLE;
                        valid_d = 1'b0;
                        data_d  = '0;
                        first_d = 1'b0;
                        last_d  = 1'b0;
`endif
                    end
                end
            end
`ifdef ARCTIC_SCAN_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    data_d  = '0;
                    first_d = 1'b0;
                    last_d  = 1'b0;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                data_d  = '0;
                first_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        // An accepted step overrides the end-of-frame return to IDLE.
        if (start) begin
            state_d = SEND;
            snap_d  = cells_in;
            idx_d   = '0;
            valid_d = 1'b1;
            data_d  = cells_in[N:0];
            first_d = 1'b1;
            last_d  = FIRST_IS_LAST;
        end

        if (drop && (ovr_q != {OVR_W{1'b1}})) begin
            ovr_d = ovr_q + 1'b1;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            ovr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            first_q <= first_d;
            last_q  <= last_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_arctic_scan_out.sv
// Scoreboard bench for arctic_scan_out with CELLS=4.
// Latency: n/a.
// Backpressure: out_ready driven per scenario.
module tb_arctic_scan_out;

    localparam int N     = 3;
    localparam int CELLS = 4;
    localparam int OVR_W = 8;
`ifdef ARCTIC_SCAN_CHECKSUM_EN
    localparam int FRAME_BEATS = CELLS + 1;
`else
    localparam int FRAME_BEATS = CELLS;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   step = 1'b0;
    logic [CELLS*(N+1)-1:0] cells_in = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [N:0]             out_data;
    logic                   out_first;
    logic                   out_last;
    logic                   busy;
    logic [OVR_W-1:0]       overrun;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;

    // Expected beats: {data[3:0], first, last}
    logic [5:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [5:0] prev_beat = '0;

    arctic_scan_out #(
        .N     (N),
        .CELLS (CELLS),
        .IDX_W (2),
        .OVR_W (OVR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .step      (step),
        .cells_in  (cells_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Monitor: sampled on the falling edge, i.e. just before the edge that completes a transfer.
    always @(negedge clk) begin
        logic [5:0] e;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || {out_data, out_first, out_last} !== prev_beat) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%b beat=%h, required valid=1 beat=%h",
                             out_valid, {out_data, out_first, out_last}, prev_beat);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data=%h first=%b last=%b, required no beat",
                             out_data, out_first, out_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_data, out_first, out_last} !== e) begin
                        errors++;
                        $display("FAIL beat: got data=%h first=%b last=%b, required data=%h first=%b last=%b",
                                 out_data, out_first, out_last, e[5:2], e[1], e[0]);
                    end
                end
            end
            prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
            prev_beat  = {out_data, out_first, out_last};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [15:0] c);
        logic [3:0] v;
        logic [3:0] x;
        x = '0;
        for (int k = 0; k < CELLS; k++) begin
            v = c[k*4 +: 4];
            x = x ^ v;
            exp_q.push_back({v, (k == 0), (k == CELLS - 1) && (FRAME_BEATS == CELLS)});
        end
`ifdef ARCTIC_SCAN_CHECKSUM_EN
        exp_q.push_back({x, 1'b0, 1'b1});
`endif
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && busy === 1'b1; i++) tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_timeout: busy=%b, required 0 within 60 cycles", name, busy);
        end
    endtask

    task automatic check_drained(input string name, input int beats);
        checks++;
        if (xfer_cnt != beats || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_count: got %0d transfers (%0d left), required %0d (0 left)",
                     name, xfer_cnt, exp_q.size(), beats);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({out_valid, out_data, out_first, out_last, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required 00000000",
                     {out_valid, out_data, out_first, out_last, busy});
        end
        checks++;
        if (overrun !== 8'd0) begin
            errors++;
            $display("FAIL reset_overrun: got %0d, required 0", overrun);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        xfer_cnt  = 0;
        out_ready = 1'b1;
        cells_in  = 16'h8421;
        push_frame(16'h8421);
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h1 || out_first !== 1'b1) begin
            errors++;
            $display("FAIL first_beat_latency: got valid=%b data=%h first=%b, required 1 1 1",
                     out_valid, out_data, out_first);
        end
        repeat (FRAME_BEATS - 1) tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_mid_frame: got %b, required 1", busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_frame: got busy=%b valid=%b, required 0 0", busy, out_valid);
        end
        check_drained("basic", FRAME_BEATS);
    endtask

    task automatic test_stall();
        logic [3:0] pat;
        pat       = 4'b1001;
        xfer_cnt  = 0;
        cells_in  = 16'h8421;
        push_frame(16'h8421);
        out_ready = 1'b1;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 60 && busy === 1'b1; i++) begin
            out_ready = pat[i % 4];
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_timeout: busy=%b, required 0", busy);
        end
        out_ready = 1'b1;
        check_drained("stall", FRAME_BEATS);
    endtask

    task automatic test_snapshot();
        xfer_cnt  = 0;
        out_ready = 1'b1;
        cells_in  = 16'h8421;
        push_frame(16'h8421);
        step = 1'b1;
        tick();
        step = 1'b0;
        cells_in = 16'hFFFF;
        wait_idle("snapshot");
        check_drained("snapshot", FRAME_BEATS);
    endtask

    task automatic test_back_to_back();
        xfer_cnt  = 0;
        out_ready = 1'b1;
        cells_in  = 16'h8421;
        push_frame(16'h8421);
        push_frame(16'h5A5A);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (FRAME_BEATS - 1) tick();
        step     = 1'b1;
        cells_in = 16'h5A5A;
        tick();
        step = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_first !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: got valid=%b data=%h first=%b, required 1 a 1",
                     out_valid, out_data, out_first);
        end
        checks++;
        if (overrun !== 8'd0) begin
            errors++;
            $display("FAIL b2b_overrun: got %0d, required 0", overrun);
        end
        wait_idle("b2b");
        check_drained("b2b", 2 * FRAME_BEATS);
    endtask

    task automatic test_overrun();
        xfer_cnt  = 0;
        out_ready = 1'b0;
        cells_in  = 16'h8421;
        push_frame(16'h8421);
        step = 1'b1;
        repeat (10) tick();
        step = 1'b0;
        checks++;
        if (overrun !== 8'd9) begin
            errors++;
            $display("FAIL overrun_count: got %0d, required 9", overrun);
        end
        step = 1'b1;
        repeat (300) tick();
        step = 1'b0;
        checks++;
        if (overrun !== 8'd255) begin
            errors++;
            $display("FAIL overrun_saturate: got %0d, required 255", overrun);
        end
        out_ready = 1'b1;
        wait_idle("overrun");
        check_drained("overrun", FRAME_BEATS);
        checks++;
        if (overrun !== 8'd255) begin
            errors++;
            $display("FAIL overrun_sticky: got %0d, required 255", overrun);
        end
    endtask

    task automatic test_mid_reset();
        xfer_cnt  = 0;
        out_ready = 1'b1;
        cells_in  = 16'h8421;
        push_frame(16'h8421);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_first, out_last, busy} !== 8'h00 || overrun !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: got outs=%b overrun=%0d, required 00000000 0",
                     {out_valid, out_data, out_first, out_last, busy}, overrun);
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got busy=%b valid=%b, required 0 0", busy, out_valid);
        end
        xfer_cnt = 0;
        push_frame(16'h8421);
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_idle("post_reset");
        check_drained("post_reset", FRAME_BEATS);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_snapshot();
        test_back_to_back();
        test_overrun();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
